// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 scancode decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    GAP
  } ps2_state_e;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational set-2 scancode to ASCII table (letters, digits, space, enter).
// Built only when PS2_ASCII_EN is defined; unknown codes map to 0.
module ps2_ascii_rom (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    // NOTE: default assignment first so unmatched codes cannot infer a latch.
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Drains the ps2_keyboard FIFO and folds E0/F0 prefixes into single key events.
// Define PS2_ASCII_EN to build the registered ASCII lookup; otherwise key_ascii is 0.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             fifo_clrn,
  output logic             key_valid,
  output logic             key_make,
  output logic             key_repeat,
  output logic             key_ext,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count
);

  ps2_state_e state;
  logic       brk_pend;
  logic       ext_pend;
  logic [7:0] held_code;
  logic       held_ext;

  logic accept;
  logic is_break;
  logic is_ext;
  logic is_err;
  logic take_event;
  logic held_match;

  assign accept     = (state == IDLE) && !overflow && ready;
  assign is_break   = (data == PS2_BREAK);
  assign is_ext     = (data == PS2_EXT);
  assign is_err     = (data == PS2_ERR0) || (data == PS2_ERR1);
  assign take_event = accept && !is_break && !is_ext && !is_err;
  assign held_match = (held_code == data) && (held_ext == ext_pend);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state       <= IDLE;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      nextdata_n  <= 1'b1;
      fifo_clrn   <= 1'b1;
      key_valid   <= 1'b0;
      key_make    <= 1'b0;
      key_repeat  <= 1'b0;
      key_ext     <= 1'b0;
      key_code    <= 8'h00;
      key_down    <= 1'b0;
      press_count <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision uses pre-edge state.
      key_valid  <= 1'b0;
      nextdata_n <= 1'b1;
      fifo_clrn  <= 1'b1;
      case (state)
        IDLE: begin
          if (overflow) begin
            fifo_clrn <= 1'b0;
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            state     <= GAP;
          end else if (ready) begin
            nextdata_n <= 1'b0;
            state      <= POP;
            if (is_break) begin
              brk_pend <= 1'b1;
            end else if (is_ext) begin
              ext_pend <= 1'b1;
            end else begin
              brk_pend <= 1'b0;
              ext_pend <= 1'b0;
            end
            if (take_event) begin
              key_valid <= 1'b1;
              key_code  <= data;
              key_ext   <= ext_pend;
              if (brk_pend) begin
                key_make   <= 1'b0;
                key_repeat <= 1'b0;
                if (held_match) key_down <= 1'b0;
              end else if (key_down && held_match) begin
                key_make   <= 1'b1;
                key_repeat <= 1'b1;
              end else begin
                key_make    <= 1'b1;
                key_repeat  <= 1'b0;
                key_down    <= 1'b1;
                held_code   <= data;
                held_ext    <= ext_pend;
                press_count <= press_count + CNT_W'(1);
              end
            end
          end
        end
        // The pop strobe is already low during POP; GAP lets the read pointer settle.
        POP:     state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PS2_ASCII_EN
  logic [7:0] rom_ascii;

  ps2_ascii_rom u_ascii_rom (
    .code  (data),
    .ascii (rom_ascii)
  );

  always_ff @(posedge clk) begin
    if (!clrn) begin
      key_ascii <= 8'h00;
    end else if (take_event) begin
      key_ascii <= ext_pend ? 8'h00 : rom_ascii;
    end
  end
`else
  assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: emulated receiver FIFO, byte-level reference model, random traffic.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int CNT_W = 8;

  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] KEYS [8] = '{8'h1C, 8'h32, 8'h16, 8'h1E, 8'h75, 8'h29, 8'h5A, 8'h6B};

  logic             clk = 1'b0;
  logic             clrn;
  logic [7:0]       data;
  logic             ready;
  logic             overflow;
  logic             nextdata_n;
  logic             fifo_clrn;
  logic             key_valid;
  logic             key_make;
  logic             key_repeat;
  logic             key_ext;
  logic [7:0]       key_code;
  logic [7:0]       key_ascii;
  logic             key_down;
  logic [CNT_W-1:0] press_count;

  ps2_key_decoder #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .data        (data),
    .ready       (ready),
    .overflow    (overflow),
    .nextdata_n  (nextdata_n),
    .fifo_clrn   (fifo_clrn),
    .key_valid   (key_valid),
    .key_make    (key_make),
    .key_repeat  (key_repeat),
    .key_ext     (key_ext),
    .key_code    (key_code),
    .key_ascii   (key_ascii),
    .key_down    (key_down),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Receiver FIFO emulation and reference model state.
  logic [7:0] q[$];
  bit         ovf_pend = 1'b0;
  bit         prev_nd  = 1'b1;
  bit         prev_fc  = 1'b1;
  bit         m_brk, m_ext, m_down, m_hext;
  logic [7:0] m_hcode, m_code, m_ascii;
  int         m_cnt;
  int         ev_cnt = 0;
  int         rep_cnt = 0;
  bit         obs_make, obs_rep, obs_ext;

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit ext);
`ifdef PS2_ASCII_EN
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++) if (LETTERS[i] == code) return 8'(97 + i);
    for (int i = 0; i < 10; i++) if (DIGITS[i] == code) return 8'(48 + i);
    if (code == 8'h29) return 8'h20;
    if (code == 8'h5A) return 8'h0D;
`endif
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_down = 0; m_hext = 0;
    m_hcode = 8'h00; m_code = 8'h00; m_ascii = 8'h00; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit v, output bit mk,
                            output bit rp, output bit ex);
    v = 0; mk = 0; rp = 0; ex = m_ext;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_brk = 0; m_ext = 0;
    end else begin
      v = 1;
      m_code  = b;
      m_ascii = ref_ascii(b, m_ext);
      if (m_brk) begin
        if (m_down && m_hcode == b && m_hext == m_ext) m_down = 0;
      end else if (m_down && m_hcode == b && m_hext == m_ext) begin
        mk = 1; rp = 1;
      end else begin
        mk = 1; m_down = 1; m_hcode = b; m_hext = m_ext;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic drive();
    ready = (q.size() > 0);
    data  = ready ? q[0] : 8'h00;
  endtask

  task automatic monitor();
    bit v, mk, rp, ex;
    logic [7:0] b;
    check("nd_back_to_back", 32'(!nextdata_n && !prev_nd), 0);
    check("nd_during_clear", 32'(!nextdata_n && !fifo_clrn), 0);
    if (!fifo_clrn) begin
      check("clear_requested", 32'(ovf_pend), 1);
      check("clear_width", 32'(prev_fc), 1);
      m_brk = 0; m_ext = 0;
      q.delete();
      overflow = 1'b0;
      ovf_pend = 1'b0;
    end
    if (!nextdata_n) begin
      check("pop_nonempty", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        b = q.pop_front();
        model_byte(b, v, mk, rp, ex);
        check("key_valid", 32'(key_valid), 32'(v));
        if (v) begin
          check("key_make", 32'(key_make), 32'(mk));
          check("key_repeat", 32'(key_repeat), 32'(rp));
          check("key_ext", 32'(key_ext), 32'(ex));
        end
        check("key_code", 32'(key_code), 32'(m_code));
        check("key_ascii", 32'(key_ascii), 32'(m_ascii));
        check("key_down", 32'(key_down), 32'(m_down));
        check("press_count", 32'(press_count), 32'(m_cnt));
      end
    end else begin
      check("valid_without_pop", 32'(key_valid), 0);
    end
    if (key_valid) begin
      ev_cnt++;
      if (key_repeat) rep_cnt++;
      obs_make = key_make; obs_rep = key_repeat; obs_ext = key_ext;
    end
    prev_nd = nextdata_n;
    prev_fc = fifo_clrn;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    drive();
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
  endtask

  // Drain everything pushed from an idle DUT; a full queue pops every 3 cycles.
  task automatic run();
    int n, cyc;
    n = q.size();
    cyc = 0;
    drive();
    while (q.size() > 0 && cyc < 3 * n + 8) begin
      cycle();
      cyc++;
    end
    check("drain_cycles", cyc, 3 * n - 2);
    repeat (2) cycle();
  endtask

  task automatic reset_dut();
    clrn = 1'b0;
    overflow = 1'b0;
    ovf_pend = 1'b0;
    q.delete();
    model_reset();
    drive();
    cycle();
    check("rst_nextdata_n", 32'(nextdata_n), 1);
    check("rst_fifo_clrn", 32'(fifo_clrn), 1);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_make", 32'(key_make), 0);
    check("rst_key_repeat", 32'(key_repeat), 0);
    check("rst_key_ext", 32'(key_ext), 0);
    check("rst_key_code", 32'(key_code), 0);
    check("rst_key_ascii", 32'(key_ascii), 0);
    check("rst_key_down", 32'(key_down), 0);
    check("rst_press_count", 32'(press_count), 0);
    clrn = 1'b1;
  endtask

  task automatic do_overflow();
    int cyc;
    overflow = 1'b1;
    ovf_pend = 1'b1;
    cyc = 0;
    while (ovf_pend && cyc < 10) begin
      cycle();
      cyc++;
    end
    check("ovf_latency", cyc, 1);
    overflow = 1'b0;
    ovf_pend = 1'b0;
    cycle();
    check("fifo_clrn_one_cycle", 32'(fifo_clrn), 1);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 20) return 8'hF0;
    if (r < 32) return 8'hE0;
    if (r < 36) return ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    if (r < 90) return KEYS[$urandom_range(0, 7)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ev0, rep0;
    clrn = 1'b0; overflow = 1'b0; ready = 1'b0; data = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    reset_dut();

    // Single press: latency and one-cycle strobes.
    push(8'h1C);
    drive();
    cycle();
    check("t1_nd_low", 32'(nextdata_n), 0);
    check("t1_valid_high", 32'(key_valid), 1);
    cycle();
    check("t1_nd_high", 32'(nextdata_n), 1);
    check("t1_valid_low", 32'(key_valid), 0);
    cycle();
    check("t1_code", 32'(key_code), 32'h1C);
    check("t1_down", 32'(key_down), 1);
    check("t1_count", 32'(press_count), 1);
`ifdef PS2_ASCII_EN
    check("t1_ascii", 32'(key_ascii), 32'h61);
`else
    check("t1_ascii", 32'(key_ascii), 32'h00);
`endif

    // Typematic repeats, then a release.
    reset_dut();
    ev0 = ev_cnt; rep0 = rep_cnt;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    run();
    check("t2_events", ev_cnt - ev0, 4);
    check("t2_repeats", rep_cnt - rep0, 2);
    check("t2_count", 32'(press_count), 1);
    check("t2_release", 32'(obs_make), 0);
    check("t2_down", 32'(key_down), 0);

    // Extended press and release.
    push(8'hE0); push(8'h75);
    run();
    check("t3_press_ext", 32'(obs_ext), 1);
    check("t3_press_make", 32'(obs_make), 1);
    check("t3_press_ascii", 32'(key_ascii), 0);
    push(8'hE0); push(8'hF0); push(8'h75);
    run();
    check("t3_rel_ext", 32'(obs_ext), 1);
    check("t3_rel_make", 32'(obs_make), 0);
    check("t3_rel_down", 32'(key_down), 0);
    check("t3_rel_ascii", 32'(key_ascii), 0);

    // Overflow clear discards a pending break.
    reset_dut();
    push(8'hF0);
    run();
    do_overflow();
    push(8'h1C);
    run();
    check("t4_make", 32'(obs_make), 1);
    check("t4_down", 32'(key_down), 1);
    check("t4_count", 32'(press_count), 1);

    // Press counter wrap.
    reset_dut();
    for (int i = 0; i < 256; i++) begin
      push((i % 2 == 0) ? 8'h16 : 8'h1E);
      run();
      if (i == 254) check("t5_count_255", 32'(press_count), 255);
    end
    check("t5_count_wrap", 32'(press_count), 0);

    // Reset after a break prefix discards it.
    reset_dut();
    push(8'hF0);
    run();
    reset_dut();
    push(8'h1C);
    run();
    check("t6_make", 32'(obs_make), 1);
    check("t6_down", 32'(key_down), 1);
    check("t6_count", 32'(press_count), 1);

    // Random traffic.
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 29);
      if (r == 0) reset_dut();
      else if (r < 3) do_overflow();
      else begin
        int len;
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) push(rand_byte());
        run();
      end
    end

    repeat (3) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
